// File: rtl/aap_decode_pkg.sv
// aap_decode_pkg: shared constants and types for the AAP decode stage.
//   - Class codes (AAP_CLASS_*), field widths, skid-buffer state encodings
//     (DEC_EMPTY / DEC_ONE / DEC_TWO) and the decoded bundle layout.
//   - imm_extend(): widens the raw immediate to 16 bits, sign-extending
//     for branches and zero-extending otherwise.
package aap_decode_pkg;

    localparam int AAP_INSTR_W  = 32;
    localparam int AAP_PC_W     = 24;
    localparam int AAP_OPCODE_W = 8;
    localparam int AAP_REG_W    = 6;
    localparam int AAP_IMM_W    = 16;

    typedef enum logic [1:0] {
        AAP_CLASS_ALU    = 2'd0,
        AAP_CLASS_LDST   = 2'd1,
        AAP_CLASS_BRANCH = 2'd2,
        AAP_CLASS_MISC   = 2'd3
    } aap_class_e;

    typedef enum logic [1:0] {
        DEC_EMPTY = 2'd0,
        DEC_ONE   = 2'd1,
        DEC_TWO   = 2'd2
    } dec_state_e;

    typedef struct packed {
        logic [AAP_PC_W-1:0]     pc;
        logic                    is_long;
        logic [1:0]              cls;
        logic [AAP_OPCODE_W-1:0] opcode;
        logic [AAP_REG_W-1:0]    rd;
        logic [AAP_REG_W-1:0]    ra;
        logic [AAP_REG_W-1:0]    rb;
        logic [AAP_IMM_W-1:0]    imm;
        logic                    illegal;
    } aap_bundle_t;

    // Short immediates are 3 bits wide, long ones 8 bits; the sign bit
    // therefore sits at raw[2] or raw[7].
    function automatic logic [AAP_IMM_W-1:0] imm_extend(input logic [7:0] raw,
                                                        input logic       is_long,
                                                        input logic       sign_en);
        logic [AAP_IMM_W-1:0] ext;
        ext = {8'd0, raw};
        if (sign_en) begin
            if (is_long) begin
                ext = {{8{raw[7]}}, raw};
            end else begin
                ext = {{13{raw[2]}}, raw[2:0]};
            end
        end else begin
            ext = {8'd0, raw};
        end
        return ext;
    endfunction

endpackage

// File: rtl/aap_decode_fields.sv
// aap_decode_fields: purely combinational instruction -> decoded bundle.
//   instr  in  32 : fetched word, first halfword in [31:16]
//   pc     in  24 : PC of the first halfword
//   bundle out    : decoded fields (aap_bundle_t)
// Optional build macro AAP_DECODE_ILLEGAL_EN enables illegal-encoding
// detection; without it bundle.illegal is always 0.
module aap_decode_fields
    import aap_decode_pkg::*;
(
    input  logic [AAP_INSTR_W-1:0] instr,
    input  logic [AAP_PC_W-1:0]    pc,
    output aap_bundle_t            bundle
);

    logic [7:0] imm_raw_s;

    // Field extraction; the second halfword only contributes for long words.
    always_comb begin
        bundle         = '0;
        imm_raw_s      = 8'd0;
        bundle.pc      = pc;
        bundle.is_long = instr[31];
        bundle.cls     = instr[30:29];
        if (instr[31]) begin
            bundle.opcode = {instr[12:9], instr[28:25]};
            bundle.rd     = {instr[8:6], instr[24:22]};
            bundle.ra     = {instr[5:3], instr[21:19]};
            bundle.rb     = {instr[2:0], instr[18:16]};
            imm_raw_s     = {instr[14:13], instr[2:0], instr[18:16]};
        end else begin
            bundle.opcode = {4'd0, instr[28:25]};
            bundle.rd     = {3'd0, instr[24:22]};
            bundle.ra     = {3'd0, instr[21:19]};
            bundle.rb     = {3'd0, instr[18:16]};
            imm_raw_s     = {5'd0, instr[18:16]};
        end
        bundle.imm = imm_extend(imm_raw_s, instr[31], instr[30:29] == AAP_CLASS_BRANCH);
`ifdef AAP_DECODE_ILLEGAL_EN
        // Bit 15 of a long word would announce a further halfword.
        bundle.illegal = (instr[31] & instr[15]) |
                         ((instr[30:29] == AAP_CLASS_MISC) && (bundle.opcode[7:4] != 4'd0));
`else
        bundle.illegal = 1'b0;
`endif
    end

`ifndef AAP_DECODE_ILLEGAL_EN
    logic unused_bit15_s;
    assign unused_bit15_s = instr[15];
`endif

endmodule

// File: rtl/aap_decode.sv
// aap_decode: AAP decode stage with a two-entry skid buffer.
//   clk, rst_n (async active-low)
//   in_valid/in_ready/in_instr/in_pc : from fetch
//   flush                            : drop everything buffered and the
//                                      same-cycle input
//   out_valid/out_ready/out_*        : decoded bundle to execute
// Optional build macro AAP_DECODE_ILLEGAL_EN (see aap_decode_fields).
// in_ready is a register (high unless both entries are full), so out_ready
// never reaches in_ready combinationally.
module aap_decode
    import aap_decode_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [AAP_INSTR_W-1:0]  in_instr,
    input  logic [AAP_PC_W-1:0]     in_pc,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [AAP_PC_W-1:0]     out_pc,
    output logic                    out_long,
    output logic [1:0]              out_class,
    output logic [AAP_OPCODE_W-1:0] out_opcode,
    output logic [AAP_REG_W-1:0]    out_rd,
    output logic [AAP_REG_W-1:0]    out_ra,
    output logic [AAP_REG_W-1:0]    out_rb,
    output logic [AAP_IMM_W-1:0]    out_imm,
    output logic                    out_illegal
);

    dec_state_e  state_r;
    aap_bundle_t out_r;
    aap_bundle_t skid_r;
    logic        out_valid_r;
    logic        in_ready_r;
    aap_bundle_t dec_s;
    logic        accept_s;
    logic        drain_s;

    aap_decode_fields u_fields (
        .instr  (in_instr),
        .pc     (in_pc),
        .bundle (dec_s)
    );

    // Handshake qualifiers for this cycle.
    always_comb begin
        accept_s = in_valid & in_ready_r;
        drain_s  = out_valid_r & out_ready;
    end

    // Skid-buffer FSM: state, entry registers and both valid/ready flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= DEC_EMPTY;
            out_r       <= '0;
            skid_r      <= '0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else if (flush) begin
            state_r     <= DEC_EMPTY;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            case (state_r)
                DEC_EMPTY: begin
                    if (accept_s) begin
                        out_r       <= dec_s;
                        out_valid_r <= 1'b1;
                        state_r     <= DEC_ONE;
                    end
                end
                DEC_ONE: begin
                    if (accept_s && !drain_s) begin
                        skid_r     <= dec_s;
                        in_ready_r <= 1'b0;
                        state_r    <= DEC_TWO;
                    end else if (accept_s && drain_s) begin
                        out_r <= dec_s;
                    end else if (drain_s) begin
                        out_valid_r <= 1'b0;
                        state_r     <= DEC_EMPTY;
                    end
                end
                DEC_TWO: begin
                    if (drain_s) begin
                        out_r      <= skid_r;
                        in_ready_r <= 1'b1;
                        state_r    <= DEC_ONE;
                    end
                end
                default: begin
                    state_r     <= DEC_EMPTY;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign out_pc      = out_r.pc;
    assign out_long    = out_r.is_long;
    assign out_class   = out_r.cls;
    assign out_opcode  = out_r.opcode;
    assign out_rd      = out_r.rd;
    assign out_ra      = out_r.ra;
    assign out_rb      = out_r.rb;
    assign out_imm     = out_r.imm;
    assign out_illegal = out_r.illegal;

endmodule

// File: tb/tb_aap_decode.sv
// tb_aap_decode: scoreboard bench for aap_decode. Expected bundles are
// produced by a halfword-oriented reference decoder when an instruction is
// accepted and compared when execute drains one.
module tb_aap_decode;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [23:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_pc;
    logic        out_long;
    logic [1:0]  out_class;
    logic [7:0]  out_opcode;
    logic [5:0]  out_rd, out_ra, out_rb;
    logic [15:0] out_imm;
    logic        out_illegal;

    int n_cmp = 0;
    int n_mis = 0;
    logic [69:0] sb_q[$];
    logic        hold_v = 1'b0;
    logic [69:0] held_b = '0;

    aap_decode dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_long(out_long), .out_class(out_class), .out_opcode(out_opcode),
        .out_rd(out_rd), .out_ra(out_ra), .out_rb(out_rb), .out_imm(out_imm),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    wire [69:0] obs_b = {out_pc, out_long, out_class, out_opcode, out_rd, out_ra,
                         out_rb, out_imm, out_illegal};

    task automatic check_eq(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference decoder working on the two halfwords.
    function automatic logic [69:0] ref_decode(input logic [31:0] w, input logic [23:0] p);
        logic [15:0] h1, h2;
        logic        lng, ill;
        logic [1:0]  c;
        logic [7:0]  op, raw;
        logic [5:0]  d, a, b;
        logic [15:0] im;
        h1  = w[31:16];
        h2  = lng_mask(w);
        lng = h1[15];
        c   = h1[14:13];
        op  = {h2[12:9], h1[12:9]};
        d   = {h2[8:6], h1[8:6]};
        a   = {h2[5:3], h1[5:3]};
        b   = {h2[2:0], h1[2:0]};
        if (lng) raw = {h2[14:13], h2[2:0], h1[2:0]};
        else     raw = {5'd0, h1[2:0]};
        if (c == 2'd2) begin
            if (lng) im = {{8{raw[7]}}, raw};
            else     im = {{13{raw[2]}}, raw[2:0]};
        end else begin
            im = {8'd0, raw};
        end
`ifdef AAP_DECODE_ILLEGAL_EN
        ill = (lng && h2[15]) || (c == 2'd3 && op[7:4] != 4'd0);
`else
        ill = 1'b0;
`endif
        return {p, lng, c, op, d, a, b, im, ill};
    endfunction

    // Second halfword as seen by decode: ignored entirely for short words.
    function automatic logic [15:0] lng_mask(input logic [31:0] w);
        return w[31] ? w[15:0] : 16'd0;
    endfunction

    // Scoreboard monitor plus output-stability check, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            hold_v = 1'b0;
        end else begin
            if (hold_v) check_eq("stall_stable", {9'd0, out_valid, obs_b}, {9'd0, 1'b1, held_b});
            hold_v = out_valid && !out_ready && !flush;
            held_b = obs_b;
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_out", {10'd0, obs_b}, 80'd0);
                end else begin
                    check_eq("bundle", {10'd0, obs_b}, {10'd0, sb_q.pop_front()});
                end
            end
            if (flush) sb_q.delete();
            else if (in_valid && in_ready) sb_q.push_back(ref_decode(in_instr, in_pc));
        end
    end

    task automatic drive(input logic v, input logic [31:0] w, input logic [23:0] p);
        @(posedge clk);
        #1;
        in_valid = v;
        in_instr = w;
        in_pc    = p;
    endtask

    task automatic wait_ready();
        int k = 0;
        @(negedge clk);
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) check_eq("accept_timeout", 80'd0, 80'd1);
    endtask

    // Present one instruction, wait for it to be taken, then go idle.
    task automatic send(input logic [31:0] w, input logic [23:0] p);
        drive(1'b1, w, p);
        wait_ready();
        drive(1'b0, 32'd0, 24'd0);
    endtask

    initial begin
        logic [31:0] r;
        rst_n = 1'b0; in_valid = 1'b0; in_instr = 32'd0; in_pc = 24'd0;
        flush = 1'b0; out_ready = 1'b1;
        #12;
        check_eq("rst_out_valid", {79'd0, out_valid}, 80'd0);
        check_eq("rst_in_ready", {79'd0, in_ready}, 80'd1);
        check_eq("rst_fields", {10'd0, obs_b}, 80'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Short load/store.
        send(32'h2A5B_0000, 24'h000100);
        check_eq("short_valid", {79'd0, out_valid}, 80'd1);
        check_eq("short_class", {78'd0, out_class}, 80'd1);
        check_eq("short_opcode", {72'd0, out_opcode}, 80'h05);
        check_eq("short_rd", {74'd0, out_rd}, 80'd1);
        check_eq("short_ra", {74'd0, out_ra}, 80'd3);
        check_eq("short_rb", {74'd0, out_rb}, 80'd3);
        check_eq("short_long", {79'd0, out_long}, 80'd0);
        check_eq("short_imm", {64'd0, out_imm}, 80'd3);

        // Long branch: raw imm {11,111,000} = 8'hF8, sign-extended.
        send(32'hC000_6007, 24'h000200);
        check_eq("long_class", {78'd0, out_class}, 80'd2);
        check_eq("long_flag", {79'd0, out_long}, 80'd1);
        check_eq("long_imm", {64'd0, out_imm}, 80'hFFF8);
        check_eq("long_rb", {74'd0, out_rb}, 80'd56);

        // Long word announcing a further halfword.
        send(32'h8000_8000, 24'h000300);
`ifdef AAP_DECODE_ILLEGAL_EN
        check_eq("illegal", {79'd0, out_illegal}, 80'd1);
`else
        check_eq("illegal", {79'd0, out_illegal}, 80'd0);
`endif

        // Stall: three back-to-back words with execute blocked.
        @(posedge clk); #1 out_ready = 1'b0;
        drive(1'b1, 32'h0240_0000, 24'h000A01);
        drive(1'b1, 32'h2480_0000, 24'h000A02);
        drive(1'b1, 32'h46C0_0000, 24'h000A03);
        @(negedge clk);
        check_eq("stall_in_ready", {79'd0, in_ready}, 80'd0);
        check_eq("stall_head_pc", {56'd0, out_pc}, 80'h000A01);
        @(negedge clk);
        check_eq("stall_still_full", {79'd0, in_ready}, 80'd0);
        @(posedge clk); #1 out_ready = 1'b1;
        wait_ready();
        drive(1'b0, 32'd0, 24'd0);
        repeat (4) @(posedge clk);

        // Flush while full with a new word on the input.
        #1 out_ready = 1'b0;
        drive(1'b1, 32'h0000_0000, 24'h000B01);
        drive(1'b1, 32'h2000_0000, 24'h000B02);
        drive(1'b1, 32'h4000_0000, 24'h000B03);
        flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check_eq("flush_out_valid", {79'd0, out_valid}, 80'd0);
        check_eq("flush_in_ready", {79'd0, in_ready}, 80'd1);
        @(posedge clk); #1 out_ready = 1'b1;
        repeat (3) @(posedge clk);

        // Random traffic with random back-pressure and occasional flushes.
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            r = $urandom;
            in_valid  = r[0];
            out_ready = (r[2:1] != 2'd0);
            flush     = (r[7:3] == 5'd0);
            in_instr  = $urandom;
            r = $urandom;
            in_pc     = r[23:0];
        end
        @(posedge clk); #1 in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (4) @(posedge clk);
        check_eq("random_drained", {48'd0, 32'(sb_q.size())}, 80'd0);

        // Asynchronous reset between edges while one bundle is held.
        #1 out_ready = 1'b0;
        send(32'h2A5B_0000, 24'h000C01);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_out_valid", {79'd0, out_valid}, 80'd0);
        check_eq("arst_in_ready", {79'd0, in_ready}, 80'd1);
        check_eq("arst_fields", {10'd0, obs_b}, 80'd0);
        @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("arst_no_replay", {79'd0, out_valid}, 80'd0);
        check_eq("sb_empty", {48'd0, 32'(sb_q.size())}, 80'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
